simple_uart_rx: RTL and testbench

SIMPLE_UART_RX -- requirements
Module: simple_uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/byte_fifo4.sv | 55 +++++
 rtl/simple_uart_rx.sv | 136 +++++++++++++
 tb/tb_simple_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the default
// bit period used by both the receiver and the transmitter.
package uart_pkg;

  // 24 MHz / 115200 baud, rounded down
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 208;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/byte_fifo4.sv
// Four-entry byte FIFO with show-ahead output. A push while full is accepted
// only when a pop frees the slot in the same cycle; otherwise o_drop flags it.
module byte_fifo4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_drop
);

  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign o_full    = (r_count == 3'd4);
  assign o_empty   = (r_count == 3'd0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;
  assign o_dout    = r_mem[r_rd_ptr];

  // NOTE: storage is reset deliberately so the head reads 0 while empty;
  // drop the reset here if that guarantee is ever not needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : byte_fifo4

// File: rtl/simple_uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, sticky error flags
// and a 4-byte receive FIFO.
module simple_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_24MHz,
  input  logic       rst,
  input  logic       serial,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       valid,
  output logic       full,
  output logic       overrun,
  output logic       frame_err,
  output logic [3:0] debug
);

  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

  rx_state_t   r_state;
  rx_state_t   w_next;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_overrun;
  logic        r_frame_err;
  logic        w_cnt_done;
  logic        w_busy;
  logic        w_sample;
  logic        w_push;
  logic        w_stop_bad;
  logic        w_empty;
  logic        w_drop;

  assign w_cnt_done = (r_cnt == 16'd0);

  // NOTE: every clocked register uses <= so all flops see pre-edge values;
  // blocking assignments here would make the sync chain collapse to one stage.
  always_ff @(posedge clk_24MHz) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_24MHz) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next defaults to the current state so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!r_sync2) w_next = ST_START;
      ST_START: if (w_cnt_done) w_next = r_sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_cnt_done && r_bit_idx == 3'd7) w_next = ST_STOP;
      ST_STOP:  if (w_cnt_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != ST_IDLE);
    w_sample   = w_cnt_done && (r_state == ST_DATA || r_state == ST_STOP);
    w_push     = w_cnt_done && (r_state == ST_STOP) && r_sync2;
    w_stop_bad = w_cnt_done && (r_state == ST_STOP) && !r_sync2;
  end

  always_ff @(posedge clk_24MHz) begin
    if (rst) begin
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_idx <= 3'd0;
          r_cnt     <= r_sync2 ? 16'd0 : HALF_LOAD;
        end
        ST_START: r_cnt <= w_cnt_done ? BIT_LOAD : r_cnt - 16'd1;
        ST_DATA: begin
          if (w_cnt_done) begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            r_cnt     <= BIT_LOAD;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_STOP:  r_cnt <= w_cnt_done ? 16'd0 : r_cnt - 16'd1;
        default:  r_cnt <= 16'd0;
      endcase
    end
  end

  // Error flags are sticky; a same-cycle error event beats clr_err.
  always_ff @(posedge clk_24MHz) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)       r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
      if (w_stop_bad)   r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
    end
  end

  byte_fifo4 u_fifo (
    .clk     (clk_24MHz),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (rd),
    .i_din   (r_shift),
    .o_dout  (data),
    .o_full  (full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign valid     = ~w_empty;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign debug     = {w_busy, w_sample, r_sync2, w_push};

endmodule : simple_uart_rx

// File: tb/tb_simple_uart_rx.sv
// Directed bench for simple_uart_rx at 16 clocks per bit; received bytes are
// checked by a scoreboard monitor on every rd handshake.
module tb_simple_uart_rx;

  localparam int C = 16;
  localparam int LAT_NOM = 9 * C + C / 2 + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial;
  logic       rd;
  logic       clr_err;
  logic [7:0] data;
  logic       valid;
  logic       full;
  logic       overrun;
  logic       frame_err;
  logic [3:0] dbg;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  simple_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_24MHz (clk),
    .rst       (rst),
    .serial    (serial),
    .rd        (rd),
    .clr_err   (clr_err),
    .data      (data),
    .valid     (valid),
    .full      (full),
    .overrun   (overrun),
    .frame_err (frame_err),
    .debug     (dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame LSB first; max_ticks < 10*C aborts it part-way.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int max_ticks);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int t = 0; t < 10 * C && t < max_ticks; t++) begin
      serial = f[t / C];
      tick();
    end
    serial = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1, 10 * C);
  endtask

  task automatic pop_one();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // Scoreboard monitor: sampled on the falling edge, before the popping edge.
  always @(negedge clk) begin
    if (!rst && rd && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h expected=none", data);
      end else begin
        check("pop_data", data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; serial = 1'b1; rd = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    check("rst_valid", valid, 0);
    check("rst_full", full, 0);
    check("rst_data", data, 8'h00);
    check("rst_flags", {overrun, frame_err}, 2'b00);
    check("rst_debug", dbg, 4'b0010);
    rst = 1'b0;
    repeat (4) tick();

    // Four back-to-back frames fill the FIFO
    send_good(8'h41); send_good(8'h42); send_good(8'h43); send_good(8'h44);
    repeat (4) tick();
    check("fill_full", full, 1);
    check("fill_valid", valid, 1);
    check("fill_head", data, 8'h41);
    repeat (4) pop_one();
    check("drain_valid", valid, 0);
    check("drain_full", full, 0);

    // rd while empty is ignored
    pop_one();
    check("rd_empty_valid", valid, 0);
    check("rd_empty_overrun", overrun, 0);

    // Overrun on a fifth frame, then clear
    send_good(8'h41); send_good(8'h42); send_good(8'h43); send_good(8'h44);
    send_frame(8'h45, 1'b1, 10 * C);
    repeat (4) tick();
    check("ovr_flag", overrun, 1);
    check("ovr_head", data, 8'h41);
    check("ovr_full", full, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovr_clear", overrun, 0);
    repeat (4) pop_one();
    check("ovr_drain_valid", valid, 0);

    // Push and pop in the same cycle while full
    send_good(8'h41); send_good(8'h42); send_good(8'h43); send_good(8'h44);
    exp_q.push_back(8'h46);
    fork
      send_frame(8'h46, 1'b1, 10 * C);
      begin
        n = 0;
        while (!dbg[0] && n < 300) begin tick(); n++; end
        if (n >= 300) begin
          checks++; errors++;
          $display("FAIL push_strobe_wait actual=timeout expected=strobe");
        end
        rd = 1'b1; tick(); rd = 1'b0;
      end
    join
    repeat (4) tick();
    check("pp_overrun", overrun, 0);
    check("pp_full", full, 1);
    check("pp_head", data, 8'h42);
    repeat (4) pop_one();
    check("pp_drain_valid", valid, 0);

    // Frame error: stop bit low, byte dropped
    send_frame(8'h55, 1'b0, 10 * C);
    repeat (2 * C) tick();
    check("fe_flag", frame_err, 1);
    check("fe_valid", valid, 0);
    check("fe_idle", dbg[3], 0);

    // Good frame afterwards, with latency from start edge to valid
    exp_q.push_back(8'h0F);
    fork
      send_frame(8'h0F, 1'b1, 10 * C);
      begin
        n = 0;
        while (!valid && n < 300) begin tick(); n++; end
        checks++;
        if (n < LAT_NOM - 1 || n > LAT_NOM + 1) begin
          errors++;
          $display("FAIL latency actual=%0d expected=%0d+/-1", n, LAT_NOM);
        end
      end
    join
    check("fe_next_head", data, 8'h0F);
    pop_one();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("fe_clear", frame_err, 0);

    // Short low glitch on an idle line
    serial = 1'b0;
    repeat (4) tick();
    check("glitch_busy", dbg[3], 1);
    repeat (2) tick();
    serial = 1'b1;
    repeat (3 * C) tick();
    check("glitch_idle", dbg[3], 0);
    check("glitch_valid", valid, 0);
    check("glitch_flags", {overrun, frame_err}, 2'b00);

    // Reset during data bit 3 of 0x3C abandons the frame
    send_frame(8'h3C, 1'b1, 4 * C + C / 2);
    check("mid_busy", dbg[3], 1);
    rst = 1'b1;
    repeat (2) tick();
    check("mid_rst_debug", dbg, 4'b0010);
    check("mid_rst_out", {valid, full, overrun, frame_err}, 4'b0000);
    check("mid_rst_data", data, 8'h00);
    rst = 1'b0;
    repeat (2 * C) tick();
    check("mid_no_push", valid, 0);
    send_good(8'hA5);
    repeat (2) tick();
    check("after_rst_head", data, 8'hA5);
    pop_one();
    repeat (2) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_simple_uart_rx
